// File: rtl/conv_ctrl_pkg.sv
// State codes shared between the window sequencer and the register-write decode.
package conv_ctrl_pkg;

  localparam int STATE_W = 4;

  // LOAD is pinned to 3 because the register-write decode keys on it; code 2 is unused.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_SETUP    = 4'd1,
    ST_LOAD     = 4'd3,
    ST_COMPUTE  = 4'd4,
    ST_WAIT_MAC = 4'd5,
    ST_NEXT     = 4'd6,
    ST_DONE     = 4'd7
  } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/conv_window_sequencer.sv
// Convolution input-path sequencer: loads NUM_REGS IFM words per window, launches the MAC,
// and repeats for the programmed window count. Optional MAC watchdog under SEQ_TIMEOUT_EN.
module conv_window_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_windows,
  input  logic                  ifm_valid,
  input  logic [DATA_WIDTH-1:0] ifm_data,
  output logic                  ifm_ready,
  output logic [NUM_REGS-1:0]   reg_write,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic [3:0]            current_state,
  output logic [15:0]           counter_ifm,
  output logic                  mac_start,
  input  logic                  mac_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [15:0] NUM_REGS_C = 16'(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("conv_window_sequencer: parameter out of range");
  end

  seq_state_e            state_q, state_d;
  logic [15:0]           counter_q, counter_d;
  logic [15:0]           windows_q, windows_d;
  logic [15:0]           window_cnt_q, window_cnt_d;
  logic [NUM_REGS-1:0]   reg_write_q, reg_write_d;
  logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
  logic                  wd_expire;

`ifdef SEQ_TIMEOUT_EN
  logic error_q, error_d;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_WAIT_MAC),
    .en     (state_q == ST_WAIT_MAC),
    .expire (wd_expire)
  );

  // mac_done arriving on the expiry cycle still wins, so error is only set on a true miss.
  always_comb begin
    error_d = error_q;
    if (state_q == ST_IDLE && start) begin
      error_d = 1'b0;
    end else if (state_q == ST_WAIT_MAC && !mac_done && wd_expire) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    windows_d    = windows_q;
    window_cnt_d = window_cnt_q;
    reg_write_d  = '0;
    reg_data_d   = reg_data_q;
    ifm_ready    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          windows_d    = num_windows;
          window_cnt_d = '0;
          state_d      = (num_windows == 16'd0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        counter_d = '0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        ifm_ready = (counter_q < NUM_REGS_C);
        if (counter_q == NUM_REGS_C) begin
          state_d = ST_COMPUTE;
        end else if (ifm_valid) begin
          counter_d   = counter_q + 16'd1;
          reg_write_d = NUM_REGS'(1) << counter_q;
          reg_data_d  = ifm_data;
        end
      end
      ST_COMPUTE: state_d = ST_WAIT_MAC;
      ST_WAIT_MAC: begin
        if (mac_done) begin
          state_d = ST_NEXT;
        end else if (wd_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_NEXT: begin
        window_cnt_d = window_cnt_q + 16'd1;
        state_d      = (window_cnt_q + 16'd1 == windows_q) ? ST_DONE : ST_SETUP;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Clearing on entry keeps counter_ifm at 0 for the whole SETUP cycle.
    if (state_d == ST_SETUP) begin
      counter_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      windows_q    <= '0;
      window_cnt_q <= '0;
      reg_write_q  <= '0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      windows_q    <= windows_d;
      window_cnt_q <= window_cnt_d;
      reg_write_q  <= reg_write_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign current_state = state_q;
  assign counter_ifm   = counter_q;
  assign reg_write     = reg_write_q;
  assign reg_data      = reg_data_q;
  assign mac_start     = (state_q == ST_COMPUTE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: job table plus randomized jobs against an event-level model.
module tb_conv_window_sequencer;

  localparam int DW = 32;
  localparam int NR = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, start, ifm_valid, ifm_ready, mac_start, mac_done, busy, done, error;
  logic [15:0]   num_windows, counter_ifm;
  logic [DW-1:0] ifm_data, reg_data;
  logic [NR-1:0] reg_write;
  logic [3:0]    current_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv_window_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_windows   (num_windows),
    .ifm_valid     (ifm_valid),
    .ifm_data      (ifm_data),
    .ifm_ready     (ifm_ready),
    .reg_write     (reg_write),
    .reg_data      (reg_data),
    .current_state (current_state),
    .counter_ifm   (counter_ifm),
    .mac_start     (mac_start),
    .mac_done      (mac_done),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, current_state, 0);
    chk({tag, "_counter"}, counter_ifm, 0);
    chk({tag, "_reg_write"}, reg_write, 0);
    chk({tag, "_reg_data"}, reg_data, 0);
    chk({tag, "_ready"}, ifm_ready, 0);
    chk({tag, "_mac_start"}, mac_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // vmode: 0 = valid always high with data 1,2,3..., 1 = toggling, 2 = random.
  // mdelay < 0 withholds mac_done. rst_at > 0 resets once that many beats are accepted.
  typedef struct {
    int nw;
    int vmode;
    int mdelay;
    bit inject;
    int rst_at;
    int exp_str;
    int exp_mac;
    int exp_done;
  } job_t;

  task automatic run_job(input job_t j);
    int strobes, macs, dones, beats, win_beats, cyc, first_ready, done_cyc, wait_cyc, mac_cnt, pend_idx;
    bit pend, armed, fin, was_reset;
    logic [DW-1:0] pend_data, word;
    strobes = 0; macs = 0; dones = 0; beats = 0; win_beats = 0; cyc = 0;
    first_ready = -1; done_cyc = -1; wait_cyc = 0; mac_cnt = 0; pend_idx = 0;
    pend = 0; armed = 0; fin = 0; was_reset = 0; pend_data = '0;
    start = 1'b1; num_windows = 16'(j.nw); ifm_valid = 1'b0; mac_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      start = 1'b0;
      mac_done = 1'b0;
      chk("state_code_2", longint'(current_state == 4'd2), 0);
      chk("busy", busy, longint'(current_state != 4'd0));
      chk("ready_outside_load", longint'(ifm_ready && current_state != 4'd3), 0);
      if (pend) begin
        chk("strobe", reg_write, longint'(1) << pend_idx);
        chk("reg_data", reg_data, pend_data);
        strobes++;
        if (pend_idx == NR - 1) begin
          chk("last_strobe_state", current_state, 3);
          chk("last_strobe_ready", ifm_ready, 0);
        end
      end else begin
        chk("no_strobe", reg_write, 0);
      end
      pend = 0;
      if (current_state == 4'd1) begin
        chk("setup_counter", counter_ifm, 0);
        win_beats = 0;
      end
      if (current_state == 4'd3) chk("load_counter", counter_ifm, win_beats);
      if (ifm_ready && first_ready < 0) first_ready = cyc;
      if (current_state == 4'd5) wait_cyc++;
      if (armed) begin
        if (mac_cnt == 0) begin
          mac_done = 1'b1;
          armed = 0;
        end else begin
          mac_cnt--;
        end
      end
      if (mac_start) begin
        chk("mac_after_full_window", beats, NR * (macs + 1));
        macs++;
        if (j.mdelay >= 0) begin
          armed = 1;
          mac_cnt = j.mdelay;
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("done_windows", macs, j.nw);
        chk("done_error", error, longint'(j.mdelay < 0));
        if (j.mdelay < 0) chk("timeout_wait_cycles", wait_cyc, TO);
        fin = 1;
      end else if (j.rst_at > 0 && beats == j.rst_at) begin
        rst = 1'b1;
        ifm_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset("midjob_reset");
        fin = 1;
        was_reset = 1;
      end else begin
        case (j.vmode)
          0:       ifm_valid = 1'b1;
          1:       ifm_valid = cyc[0];
          default: ifm_valid = 1'($urandom_range(0, 1));
        endcase
        word = (j.vmode == 0) ? DW'(beats + 1) : DW'($urandom);
        ifm_data = word;
        if (j.inject && current_state == 4'd3 && win_beats == 3) begin
          start = 1'b1;
          mac_done = 1'b1;
        end
        if (ifm_valid && ifm_ready) begin
          pend = 1;
          pend_idx = win_beats;
          pend_data = word;
          win_beats++;
          beats++;
        end
        @(negedge clk);
      end
    end
    ifm_valid = 1'b0;
    start = 1'b0;
    mac_done = 1'b0;
    if (!fin) begin
      chk("job_cycle_budget", cyc, -1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else if (!was_reset) begin
      @(negedge clk);
      chk("busy_falls", busy, 0);
      chk("done_single_cycle", done, 0);
    end
    chk("strobe_count", strobes, j.exp_str);
    chk("mac_start_count", macs, j.exp_mac);
    chk("done_count", dones, j.exp_done);
    if (j.nw > 0) chk("first_ready_latency", first_ready, 2);
    if (j.nw == 0) begin
      chk("zero_done_by_2", longint'(done_cyc >= 1 && done_cyc <= 2), 1);
      chk("zero_no_ready", longint'(first_ready < 0), 1);
    end
  endtask

  job_t table_q[$];
  job_t rj;

  initial begin
    rst = 1'b1; start = 1'b0; num_windows = '0; ifm_valid = 1'b0; ifm_data = '0; mac_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", current_state, 0);

    //                nw vm md inj rst str mac dn
    table_q.push_back('{1, 0, 0, 0, 0,  10, 1, 1});
    table_q.push_back('{3, 1, 2, 0, 0,  30, 3, 1});
    table_q.push_back('{0, 0, 0, 0, 0,  0,  0, 1});
    table_q.push_back('{2, 0, 1, 1, 0,  20, 2, 1});
    table_q.push_back('{3, 0, 0, 0, 15, 15, 1, 0});
    table_q.push_back('{1, 0, 3, 0, 0,  10, 1, 1});
    table_q.push_back('{2, 2, 4, 0, 0,  20, 2, 1});
    foreach (table_q[i]) run_job(table_q[i]);

    for (int n = 0; n < 6; n++) begin
      rj.nw = int'($urandom_range(0, 4));
      rj.vmode = 2;
      rj.mdelay = int'($urandom_range(0, 5));
      rj.inject = 1'($urandom_range(0, 1));
      rj.rst_at = 0;
      rj.exp_str = rj.nw * NR;
      rj.exp_mac = rj.nw;
      rj.exp_done = 1;
      run_job(rj);
    end

`ifdef SEQ_TIMEOUT_EN
    run_job('{1, 0, -1, 0, 0, 10, 1, 1});
    chk("error_sticky", error, 1);
    run_job('{0, 0, 0, 0, 0, 0, 0, 1});
    chk("error_cleared", error, 0);
`else
    chk("error_tied_low", error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
